shift_add_ctrl: RTL

- Parametrised Moore controller for a WIDTH-bit sequential shift-and-add multiplier datapath.
- Issues load/add/shift strobes, tracks the iteration count, and handshakes with a requester over start/busy/done/ack.
- Successor to the fixed 4-state, 8-bit load/select controller: generalised in WIDTH, with an explicit add phase, a completion handshake and optional early termination.

---
 rtl/shift_add_ctrl_pkg.sv | 36 +++
 rtl/shift_add_ctrl_if.sv | 38 +++
 rtl/shift_add_ctrl_iter_counter.sv | 50 +++++
 rtl/shift_add_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/shift_add_ctrl_pkg.sv
// ============================================================================
//  Module      : shift_add_pkg
//  Description : Shared state encoding and defaults for the shift-and-add
//                multiplier controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [2:0] ENC_IDLE  = 3'd0;
   localparam logic [2:0] ENC_LOAD  = 3'd1;
   localparam logic [2:0] ENC_TEST  = 3'd2;
   localparam logic [2:0] ENC_ADD   = 3'd3;
   localparam logic [2:0] ENC_SHIFT = 3'd4;
   localparam logic [2:0] ENC_DONE  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = ENC_IDLE,
      ST_LOAD  = ENC_LOAD,
      ST_TEST  = ENC_TEST,
      ST_ADD   = ENC_ADD,
      ST_SHIFT = ENC_SHIFT,
      ST_DONE  = ENC_DONE
   } state_t;

   // Busy covers every state in which the datapath is being sequenced.
   function automatic logic state_is_busy(input state_t s);
      return (s == ST_LOAD) || (s == ST_TEST) || (s == ST_ADD) || (s == ST_SHIFT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_add_ctrl_if.sv
// ============================================================================
//  Module      : shift_add_ctrl_if
//  Description : Requester/datapath handshake bundle for shift_add_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_add_ctrl_if
   import shift_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   localparam int CW = $clog2(WIDTH);

   logic          start;
   logic          ack;
   logic          mplr_lsb;
   logic          mplr_zero;
   logic          load;
   logic          add_en;
   logic          shift_en;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;

   modport master (
      output start, ack, mplr_lsb, mplr_zero,
      input  load, add_en, shift_en, busy, done, count
   );

   modport slave (
      input  start, ack, mplr_lsb, mplr_zero,
      output load, add_en, shift_en, busy, done, count
   );

endinterface

`default_nettype wire

// File: rtl/shift_add_ctrl_iter_counter.sv
// ============================================================================
//  Module      : iter_counter
//  Description : Iteration counter with clear, increment and a terminal flag
//                at WIDTH-1; saturates at the terminal value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_counter
   import shift_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          term
);

   localparam logic [CW-1:0] TERM_VAL = CW'(WIDTH - 1);

   logic [CW-1:0] count_d;
   logic [CW-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != TERM_VAL)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign term  = (count_q == TERM_VAL);

endmodule

`default_nettype wire

// File: rtl/shift_add_ctrl.sv
// ============================================================================
//  Module      : shift_add_ctrl
//  Description : Moore controller for a WIDTH-bit sequential shift-and-add
//                multiplier. Define SHIFT_ADD_CTRL_EARLY_TERM_EN to finish as
//                soon as the remaining multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_ctrl
   import shift_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic            clk,
   input  logic            reset,
   shift_add_ctrl_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

`ifdef SHIFT_ADD_CTRL_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   state_t        state_d;
   state_t        state_q;
   logic          load_d;
   logic          load_q;
   logic          add_en_d;
   logic          add_en_q;
   logic          shift_en_d;
   logic          shift_en_q;
   logic          busy_d;
   logic          busy_q;
   logic          done_d;
   logic          done_q;
   logic          early_done;
   logic          cnt_clr;
   logic          cnt_inc;
   logic          cnt_term;
   logic [CW-1:0] cnt_value;

   assign early_done = EARLY_TERM && bus.mplr_zero;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_TEST;
         ST_TEST: begin
            if (early_done) begin
               state_d = ST_DONE;
            end else if (bus.mplr_lsb) begin
               state_d = ST_ADD;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_ADD:   state_d = ST_SHIFT;
         ST_SHIFT: state_d = cnt_term ? ST_DONE : ST_TEST;
         ST_DONE:  if (bus.ack) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line
   // up exactly with the state they belong to.
   always_comb begin
      load_d     = (state_d == ST_LOAD);
      add_en_d   = (state_d == ST_ADD);
      shift_en_d = (state_d == ST_SHIFT);
      busy_d     = state_is_busy(state_d);
      done_d     = (state_d == ST_DONE);
   end

   // Returning to IDLE zeroes count so every output reads 0 while idle.
   always_comb begin
      cnt_clr = (state_d == ST_IDLE) || (state_q == ST_LOAD);
      cnt_inc = (state_q == ST_SHIFT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         load_q     <= 1'b0;
         add_en_q   <= 1'b0;
         shift_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         add_en_q   <= add_en_d;
         shift_en_q <= shift_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   iter_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_iter_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (cnt_value),
      .term  (cnt_term)
   );

   assign bus.load     = load_q;
   assign bus.add_en   = add_en_q;
   assign bus.shift_en = shift_en_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.count    = cnt_value;

endmodule

`default_nettype wire
